// File: rtl/opb_sim2ppc_pkg.sv
// Shared definitions for the Simulink-to-PPC OPB capture register:
// register offsets, STATUS bit positions and slave FSM state encodings.
package opb_sim2ppc_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    localparam int STAT_NEW_BIT = 31;
    localparam int STAT_OVF_BIT = 30;
    localparam int STAT_FRZ_BIT = 29;

    localparam int CTRL_CLR_OVF_BIT = 0;
    localparam int CTRL_FREEZE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } slv_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: address decode, IDLE/ACK/DONE acknowledge FSM and
// the read-data mux, which is zero outside a read ACK cycle.
module opb_slave_ack_fsm
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR = 32'h000000FF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        select_i,
    input  logic [31:0] abus_i,
    input  logic        rnw_i,
    input  logic [31:0] data_reg_i,
    input  logic [31:0] status_reg_i,
    input  logic [31:0] control_reg_i,
    output logic        xfer_ack_o,
    output logic        ack_o,
    output logic [1:0]  offset_o,
    output logic [31:0] rd_data_o
);

    localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

    slv_state_e  state_q, state_d;
    logic        hit;
    logic [31:0] rel_addr;

    // A single unsigned compare covers both window bounds: addresses below
    // the base wrap to large values and fall outside the span.
    assign rel_addr = abus_i - C_BASEADDR;
    assign hit      = select_i && (rel_addr <= SPAN);
    assign offset_o = abus_i[3:2];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = hit ? ST_ACK : ST_IDLE;
            ST_ACK:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_o      = (state_q == ST_ACK);
    assign xfer_ack_o = ack_o;

    always_comb begin
        rd_data_o = '0;
        if (ack_o && rnw_i) begin
            case (offset_o)
                REG_DATA:    rd_data_o = data_reg_i;
                REG_STATUS:  rd_data_o = status_reg_i;
                REG_CONTROL: rd_data_o = control_reg_i;
                default:     rd_data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC capture register on OPB: DATA/STATUS/CONTROL with overflow
// and freeze. Optional 16-bit capture counter under SIM2PPC_CAPTURE_COUNT_EN.
module opb_register_simulink2ppc
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_frozen
);

    logic [31:0] data_q, data_d;
    logic        new_q, new_d;
    logic        ovf_q, ovf_d;
    logic        frz_q, frz_d;
    logic [15:0] count;

    logic        ack;
    logic [1:0]  offset;
    logic [31:0] rd_data;
    logic [31:0] wdata;
    logic [31:0] status_reg;
    logic [31:0] control_reg;
    logic        capture;
    logic        rd_data_ack;
    logic        wr_ctrl;
    logic        unused_ok;

    // Reversed-range bus: OPB bit 0 lands on user bit 31.
    assign wdata = OPB_DBus;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk_i         (OPB_Clk),
        .rst_n_i       (OPB_Rst_n),
        .select_i      (OPB_select),
        .abus_i        (OPB_ABus),
        .rnw_i         (OPB_RNW),
        .data_reg_i    (data_q),
        .status_reg_i  (status_reg),
        .control_reg_i (control_reg),
        .xfer_ack_o    (Sl_xferAck),
        .ack_o         (ack),
        .offset_o      (offset),
        .rd_data_o     (rd_data)
    );

    assign capture     = user_valid && !frz_q;
    assign rd_data_ack = ack && OPB_RNW && (offset == REG_DATA);
    assign wr_ctrl     = ack && !OPB_RNW && (offset == REG_CONTROL) && OPB_BE[3];

    // A capture beats both the read-clear of new_data and the write-clear of overflow.
    always_comb begin
        data_d = data_q;
        new_d  = new_q;
        ovf_d  = ovf_q;
        frz_d  = frz_q;
        if (rd_data_ack) new_d = 1'b0;
        if (wr_ctrl) begin
            if (wdata[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
            frz_d = wdata[CTRL_FREEZE_BIT];
        end
        if (capture) begin
            data_d = user_data_in;
            new_d  = 1'b1;
            if (new_q) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovf_q  <= 1'b0;
            frz_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            new_q  <= new_d;
            ovf_q  <= ovf_d;
            frz_q  <= frz_d;
        end
    end

`ifdef SIM2PPC_CAPTURE_COUNT_EN
    logic [15:0] count_q, count_d;

    assign count_d = capture ? count_q + 16'd1 : count_q;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`else
    assign count = '0;
`endif

    always_comb begin
        status_reg               = '0;
        status_reg[STAT_NEW_BIT] = new_q;
        status_reg[STAT_OVF_BIT] = ovf_q;
        status_reg[STAT_FRZ_BIT] = frz_q;
        status_reg[15:0]         = count;
    end

    assign control_reg = {30'b0, frz_q, 1'b0};

    assign Sl_DBus     = rd_data;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = frz_q;

    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:2]};

endmodule
